// File: rtl/cpu_types_pkg.sv
// Shared types for the cache/memory subsystem: RAM handshake states and the
// responder FSM state encoding (exported so benches can decode it).
package cpu_types_pkg;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    IACC = 2'd1,
    DACC = 2'd2
  } memctl_state_t;

  localparam int unsigned WAIT_CNT_W = 16;

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin picker. On a tie the side not served last wins.
module rr_arb2 (
  input  logic req_i,
  input  logic req_d,
  input  logic last_d,
  output logic grant_d,
  output logic grant_i
);

  // D wins when alone, or on a tie when I was served last.
  assign grant_d = req_d & (~req_i | ~last_d);
  assign grant_i = req_i & (~req_d |  last_d);

endmodule

// File: rtl/cache_mem_responder.sv
// Memory-side responder: arbitrates icache/dcache requests onto one RAM port,
// handles RAM errors and timeouts, and reports completions combinationally.
// Optional feature: define MEMCTL_STATS_EN to build saturating access counters
// on stat_i/stat_dr/stat_dw; otherwise those ports are tied to zero.
module cache_mem_responder
  import cpu_types_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        iREN,
  input  logic [31:0] iaddr,
  output logic        iwait,
  output logic [31:0] iload,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  output logic        dwait,
  output logic [31:0] dload,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  ramstate_t   ramstate,
  input  logic [31:0] ramload,
  output logic        fault,
  output logic [31:0] stat_i,
  output logic [31:0] stat_dr,
  output logic [31:0] stat_dw
);

  memctl_state_t         state, next_state;
  logic                  last_d;
  logic [WAIT_CNT_W-1:0] wait_cnt;
  logic                  grant_d, grant_i;
  logic                  done_i, done_d, abort, cnt_inc, timeout_hit;

  rr_arb2 u_arb (
    .req_i   (iREN),
    .req_d   (dREN | dWEN),
    .last_d  (last_d),
    .grant_d (grant_d),
    .grant_i (grant_i)
  );

  // Abort on the last permitted non-ACCESS cycle of a granted access.
  assign timeout_hit = (wait_cnt == WAIT_CNT_W'(TIMEOUT_CYCLES - 1));

  // Next-state, RAM strobes and requester responses.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves one unassigned (no latches).
    next_state = state;
    iwait      = 1'b1;
    dwait      = 1'b1;
    iload      = '0;
    dload      = '0;
    ramREN     = 1'b0;
    ramWEN     = 1'b0;
    ramaddr    = '0;
    ramstore   = '0;
    done_i     = 1'b0;
    done_d     = 1'b0;
    abort      = 1'b0;
    cnt_inc    = 1'b0;
    case (state)
      IDLE: begin
        if (grant_d)      next_state = DACC;
        else if (grant_i) next_state = IACC;
      end
      IACC: begin
        if (!iREN) begin
          next_state = IDLE;
        end else begin
          ramREN  = 1'b1;
          ramaddr = iaddr;
          if (ramstate == ACCESS) begin
            iwait      = 1'b0;
            iload      = ramload;
            done_i     = 1'b1;
            next_state = IDLE;
          end else if (ramstate == ERROR || timeout_hit) begin
            abort      = 1'b1;
            next_state = IDLE;
          end else begin
            cnt_inc = 1'b1;
          end
        end
      end
      DACC: begin
        if (!(dREN || dWEN)) begin
          next_state = IDLE;
        end else begin
          ramaddr = daddr;
          if (dWEN) begin
            ramWEN   = 1'b1;
            ramstore = dstore;
          end else begin
            ramREN = 1'b1;
          end
          if (ramstate == ACCESS) begin
            dwait      = 1'b0;
            dload      = dWEN ? 32'h0 : ramload;
            done_d     = 1'b1;
            next_state = IDLE;
          end else if (ramstate == ERROR || timeout_hit) begin
            abort      = 1'b1;
            next_state = IDLE;
          end else begin
            cnt_inc = 1'b1;
          end
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // State register plus fairness flag, sticky fault and wait counter.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state    <= IDLE;
      last_d   <= 1'b0;
      fault    <= 1'b0;
      wait_cnt <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      state <= next_state;
      if (done_i)      last_d <= 1'b0;
      else if (done_d) last_d <= 1'b1;
      else if (abort)  last_d <= ~last_d;
      if (abort) fault <= 1'b1;
      if (state == IDLE) wait_cnt <= '0;
      else if (cnt_inc)  wait_cnt <= wait_cnt + 1'b1;
    end
  end

`ifdef MEMCTL_STATS_EN
  // Saturating completion counters per access kind.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      stat_i  <= '0;
      stat_dr <= '0;
      stat_dw <= '0;
    end else begin
      if (done_i && stat_i != '1)            stat_i  <= stat_i + 1'b1;
      if (done_d && !dWEN && stat_dr != '1)  stat_dr <= stat_dr + 1'b1;
      if (done_d && dWEN && stat_dw != '1)   stat_dw <= stat_dw + 1'b1;
    end
  end
`else
  assign stat_i  = '0;
  assign stat_dr = '0;
  assign stat_dw = '0;
`endif

endmodule

// File: tb/tb_cache_mem_responder.sv
// Directed bench for cache_mem_responder: a per-cycle vector table plus a
// hand-written asynchronous-reset sequence. TIMEOUT_CYCLES is set to 4.
module tb_cache_mem_responder;
  import cpu_types_pkg::*;

`ifdef MEMCTL_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        iREN = 1'b0, dREN = 1'b0, dWEN = 1'b0;
  logic [31:0] iaddr = '0, daddr = '0, dstore = '0, ramload = '0;
  ramstate_t   ramstate = FREE;
  logic        iwait, dwait, ramREN, ramWEN, fault;
  logic [31:0] iload, dload, ramaddr, ramstore, stat_i, stat_dr, stat_dw;

  int checks = 0;
  int errors = 0;

  cache_mem_responder #(.TIMEOUT_CYCLES(4)) dut (
    .CLK(CLK), .RST(RST),
    .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dwait(dwait), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramstate(ramstate), .ramload(ramload), .fault(fault),
    .stat_i(stat_i), .stat_dr(stat_dr), .stat_dw(stat_dw)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic          iren;
    logic [31:0]   ia;
    logic          dren, dwen;
    logic [31:0]   da, ds;
    ramstate_t     rs;
    logic [31:0]   rl;
    memctl_state_t st;
    logic          iw;
    logic [31:0]   il;
    logic          dw;
    logic [31:0]   dl;
    logic          rr, rw;
    logic [31:0]   ra, rst_data;
    logic          f;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add(input logic iren, input logic [31:0] ia, input logic dren, input logic dwen,
                     input logic [31:0] da, input logic [31:0] ds, input ramstate_t rs, input logic [31:0] rl,
                     input memctl_state_t st, input logic iw, input logic [31:0] il, input logic dw,
                     input logic [31:0] dl, input logic rr, input logic rw, input logic [31:0] ra,
                     input logic [31:0] rsd, input logic f);
    vec_t v;
    v.iren = iren; v.ia = ia; v.dren = dren; v.dwen = dwen; v.da = da; v.ds = ds; v.rs = rs; v.rl = rl;
    v.st = st; v.iw = iw; v.il = il; v.dw = dw; v.dl = dl; v.rr = rr; v.rw = rw; v.ra = ra;
    v.rst_data = rsd; v.f = f;
    vecs.push_back(v);
  endtask

  initial begin
    int ti, tdr, tdw;
    ti = 0; tdr = 0; tdw = 0;

    // iren ia dren dwen da ds rs rl | st iw il dw dl rr rw ra rstore f
    // Zero-wait I read.
    add(1, 32'h40, 0, 0, 0, 0, FREE,   32'h2002_0001, IDLE, 1, 0, 1, 0, 0, 0, 0, 0, 0);
    add(1, 32'h40, 0, 0, 0, 0, ACCESS, 32'h2002_0001, IACC, 0, 32'h2002_0001, 1, 0, 1, 0, 32'h40, 0, 0);
    add(0, 0,      0, 0, 0, 0, FREE,   0,             IDLE, 1, 0, 1, 0, 0, 0, 0, 0, 0);
    // Tie on a 2-cycle RAM: D first, then I.
    add(1, 32'h80, 1, 0, 32'h200, 0, FREE,   32'h1111_1111, IDLE, 1, 0, 1, 0, 0, 0, 0, 0, 0);
    add(1, 32'h80, 1, 0, 32'h200, 0, BUSY,   32'h1111_1111, DACC, 1, 0, 1, 0, 1, 0, 32'h200, 0, 0);
    add(1, 32'h80, 1, 0, 32'h200, 0, ACCESS, 32'h1111_1111, DACC, 1, 0, 0, 32'h1111_1111, 1, 0, 32'h200, 0, 0);
    add(1, 32'h80, 0, 0, 0, 0, FREE,   0,             IDLE, 1, 0, 1, 0, 0, 0, 0, 0, 0);
    add(1, 32'h80, 0, 0, 0, 0, BUSY,   32'h2222_2222, IACC, 1, 0, 1, 0, 1, 0, 32'h80, 0, 0);
    add(1, 32'h80, 0, 0, 0, 0, ACCESS, 32'h2222_2222, IACC, 0, 32'h2222_2222, 1, 0, 1, 0, 32'h80, 0, 0);
    // Repeat tie after I was served: D wins again.
    add(1, 32'h84, 1, 0, 32'h204, 0, FREE,   0,             IDLE, 1, 0, 1, 0, 0, 0, 0, 0, 0);
    add(1, 32'h84, 1, 0, 32'h204, 0, ACCESS, 32'h3333_3333, DACC, 1, 0, 0, 32'h3333_3333, 1, 0, 32'h204, 0, 0);
    add(1, 32'h84, 0, 0, 0, 0, FREE,   0,             IDLE, 1, 0, 1, 0, 0, 0, 0, 0, 0);
    add(1, 32'h84, 0, 0, 0, 0, ACCESS, 32'h4444_4444, IACC, 0, 32'h4444_4444, 1, 0, 1, 0, 32'h84, 0, 0);
    add(0, 0,      0, 0, 0, 0, FREE,   0,             IDLE, 1, 0, 1, 0, 0, 0, 0, 0, 0);
    // Write with dREN also high: write wins, dload stays 0.
    add(0, 0, 1, 1, 32'h100, 32'hDEAD_BEEF, FREE,   0,             IDLE, 1, 0, 1, 0, 0, 0, 0, 0, 0);
    add(0, 0, 1, 1, 32'h100, 32'hDEAD_BEEF, BUSY,   32'h5555_5555, DACC, 1, 0, 1, 0, 0, 1, 32'h100, 32'hDEAD_BEEF, 0);
    add(0, 0, 1, 1, 32'h100, 32'hDEAD_BEEF, ACCESS, 32'h5555_5555, DACC, 1, 0, 0, 0, 0, 1, 32'h100, 32'hDEAD_BEEF, 0);
    add(0, 0, 0, 0, 0, 0, FREE, 0, IDLE, 1, 0, 1, 0, 0, 0, 0, 0, 0);
    // RAM stuck BUSY: abort after 4 wait cycles, fault rises.
    add(1, 32'h300, 0, 0, 0, 0, BUSY, 0, IDLE, 1, 0, 1, 0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 4; k++)
      add(1, 32'h300, 0, 0, 0, 0, BUSY, 0, IACC, 1, 0, 1, 0, 1, 0, 32'h300, 0, 0);
    add(1, 32'h300, 0, 0, 0, 0, BUSY, 0, IDLE, 1, 0, 1, 0, 0, 0, 0, 0, 1);
    // Re-granted, then withdrawn: strobes drop the same cycle.
    add(0, 0, 0, 0, 0, 0, FREE, 0, IACC, 1, 0, 1, 0, 0, 0, 0, 0, 1);
    // RAM ERROR on a D read, then retried successfully.
    add(0, 0, 1, 0, 32'h400, 0, FREE,   0,             IDLE, 1, 0, 1, 0, 0, 0, 0, 0, 1);
    add(0, 0, 1, 0, 32'h400, 0, ERROR,  0,             DACC, 1, 0, 1, 0, 1, 0, 32'h400, 0, 1);
    add(0, 0, 1, 0, 32'h400, 0, ACCESS, 32'h6666_6666, IDLE, 1, 0, 1, 0, 0, 0, 0, 0, 1);
    add(0, 0, 1, 0, 32'h400, 0, ACCESS, 32'h6666_6666, DACC, 1, 0, 0, 32'h6666_6666, 1, 0, 32'h400, 0, 1);
    add(0, 0, 0, 0, 0, 0, FREE, 0, IDLE, 1, 0, 1, 0, 0, 0, 0, 0, 1);

    // Reset values.
    @(negedge CLK); #1;
    check("rst_state", 32'(dut.state), 32'(IDLE));
    check("rst_iwait", 32'(iwait), 32'h1);
    check("rst_dwait", 32'(dwait), 32'h1);
    check("rst_strobes", {30'h0, ramREN, ramWEN}, 32'h0);
    check("rst_ramaddr", ramaddr, 32'h0);
    check("rst_fault", 32'(fault), 32'h0);
    check("rst_stat_i", stat_i, 32'h0);
    RST = 1'b0;

    foreach (vecs[i]) begin
      @(negedge CLK);
      iREN = vecs[i].iren; iaddr = vecs[i].ia; dREN = vecs[i].dren; dWEN = vecs[i].dwen;
      daddr = vecs[i].da; dstore = vecs[i].ds; ramstate = vecs[i].rs; ramload = vecs[i].rl;
      #1;
      check($sformatf("v%0d_state", i),    32'(dut.state), 32'(vecs[i].st));
      check($sformatf("v%0d_iwait", i),    32'(iwait),     32'(vecs[i].iw));
      check($sformatf("v%0d_iload", i),    iload,          vecs[i].il);
      check($sformatf("v%0d_dwait", i),    32'(dwait),     32'(vecs[i].dw));
      check($sformatf("v%0d_dload", i),    dload,          vecs[i].dl);
      check($sformatf("v%0d_ramREN", i),   32'(ramREN),    32'(vecs[i].rr));
      check($sformatf("v%0d_ramWEN", i),   32'(ramWEN),    32'(vecs[i].rw));
      check($sformatf("v%0d_ramaddr", i),  ramaddr,        vecs[i].ra);
      check($sformatf("v%0d_ramstore", i), ramstore,       vecs[i].rst_data);
      check($sformatf("v%0d_fault", i),    32'(fault),     32'(vecs[i].f));
      if (!vecs[i].iw) ti++;
      if (!vecs[i].dw && vecs[i].dwen) tdw++;
      if (!vecs[i].dw && !vecs[i].dwen) tdr++;
    end

    check("stat_i",  stat_i,  STATS ? 32'(ti)  : 32'h0);
    check("stat_dr", stat_dr, STATS ? 32'(tdr) : 32'h0);
    check("stat_dw", stat_dw, STATS ? 32'(tdw) : 32'h0);

    // Asynchronous reset in the middle of a D access.
    @(negedge CLK);
    dREN = 1'b1; daddr = 32'h500; ramstate = BUSY; ramload = 32'h7777_7777;
    @(negedge CLK); #1;
    check("mid_state", 32'(dut.state), 32'(DACC));
    check("mid_ramREN", 32'(ramREN), 32'h1);
    RST = 1'b1; #1;
    check("arst_state", 32'(dut.state), 32'(IDLE));
    check("arst_strobes", {30'h0, ramREN, ramWEN}, 32'h0);
    check("arst_ramaddr", ramaddr, 32'h0);
    check("arst_dwait", 32'(dwait), 32'h1);
    check("arst_fault", 32'(fault), 32'h0);
    check("arst_stat_dr", stat_dr, 32'h0);
    @(negedge CLK);
    RST = 1'b0; ramstate = ACCESS;
    #1;
    check("rel_state", 32'(dut.state), 32'(IDLE));
    @(negedge CLK); #1;
    check("reserve_state", 32'(dut.state), 32'(DACC));
    check("reserve_dwait", 32'(dwait), 32'h0);
    check("reserve_dload", dload, 32'h7777_7777);
    check("reserve_ramaddr", ramaddr, 32'h500);
    @(negedge CLK);
    dREN = 1'b0; ramstate = FREE;
    #1;
    check("post_stat_dr", stat_dr, STATS ? 32'h1 : 32'h0);
    check("post_fault", 32'(fault), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
